cv32e40s_register_file_scrub: RTL and testbench

Parametrised flip-flop integer register file, successor to the plain parity-less variant. Generalised in word count, data width and read/write port count. Each word stores a per-byte parity field with alternating inversion, so an all-zero word is not a valid codeword. Every read port checks parity, and a background scrubber walks the array to catch latent faults in registers that are not being read; it sits in the ID/WB path in place of the existing register file.

---
 rtl/cv32e40s_register_file_scrub.sv | 152 +++++++++++++++
 tb/tb_cv32e40s_register_file_scrub.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cv32e40s_register_file_scrub.sv
// Flip-flop integer register file with per-byte alternating parity on every word,
// parity checking on all read ports and a background scrubber for unread registers.
module cv32e40s_register_file_scrub #(
    parameter int unsigned  NUM_WORDS       = 32,
    parameter int unsigned  DATA_WIDTH      = 32,
    parameter int unsigned  NUM_READ_PORTS  = 2,
    parameter int unsigned  NUM_WRITE_PORTS = 2,
    parameter int unsigned  ZERO_REG        = 1,
    parameter int unsigned  SCRUB_INTERVAL  = 16,
    localparam int unsigned ADDR_WIDTH      = $clog2(NUM_WORDS),
    localparam int unsigned PAR_WIDTH       = DATA_WIDTH / 8
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic [NUM_READ_PORTS*ADDR_WIDTH-1:0]  raddr_i,
    output logic [NUM_READ_PORTS*DATA_WIDTH-1:0]  rdata_o,
    output logic [NUM_READ_PORTS-1:0]             rerr_o,
    input  logic [NUM_WRITE_PORTS*ADDR_WIDTH-1:0] waddr_i,
    input  logic [NUM_WRITE_PORTS*DATA_WIDTH-1:0] wdata_i,
    input  logic [NUM_WRITE_PORTS-1:0]            we_i,
    input  logic [NUM_WRITE_PORTS-1:0]            winj_i,
    input  logic                                  scrub_en_i,
    output logic [ADDR_WIDTH-1:0]                 scrub_ptr_o,
    output logic                                  scrub_err_o,
    output logic [ADDR_WIDTH-1:0]                 scrub_err_addr_o,
    output logic                                  err_sticky_o,
    input  logic                                  err_clr_i
);

    localparam int unsigned CW_WIDTH  = PAR_WIDTH + DATA_WIDTH;
    localparam int unsigned CNT_WIDTH = $clog2(SCRUB_INTERVAL);
    localparam logic [ADDR_WIDTH-1:0] PTR_FIRST = (ZERO_REG != 0) ? ADDR_WIDTH'(1) : '0;

    typedef logic [CW_WIDTH-1:0] cw_t;
    typedef enum logic {S_WAIT, S_CHECK} scrub_state_e;

    // Odd bytes use odd parity so that the all-zero word is never a valid codeword.
    function automatic logic [PAR_WIDTH-1:0] gen_par(input logic [DATA_WIDTH-1:0] data);
        logic [PAR_WIDTH-1:0] par;
        for (int unsigned k = 0; k < PAR_WIDTH; k++) begin
            par[k] = (^data[8*k +: 8]) ^ k[0];
        end
        return par;
    endfunction

    localparam cw_t ZERO_CW = {gen_par('0), {DATA_WIDTH{1'b0}}};

    cw_t                  mem_q [NUM_WORDS];
    cw_t                  mem_d [NUM_WORDS];
    logic [PAR_WIDTH-1:0] wpar  [NUM_WRITE_PORTS];
    cw_t                  rd_cw [NUM_READ_PORTS];
    cw_t                  chk_cw;
    logic                 wr_hit;
    logic                 scrub_fail;

    scrub_state_e         state_q;
    logic [CNT_WIDTH-1:0] cnt_q;
    logic [ADDR_WIDTH-1:0] ptr_q;
    logic                 scrub_err_q;
    logic [ADDR_WIDTH-1:0] err_addr_q;
    logic                 sticky_q;

    always_comb begin
        for (int unsigned j = 0; j < NUM_WRITE_PORTS; j++) begin
            wpar[j]    = gen_par(wdata_i[j*DATA_WIDTH +: DATA_WIDTH]);
            wpar[j][0] = wpar[j][0] ^ winj_i[j];
        end
    end

    // Later ports overwrite earlier ones, giving the highest index priority.
    always_comb begin
        mem_d = mem_q;
        for (int unsigned j = 0; j < NUM_WRITE_PORTS; j++) begin
            if (we_i[j] && !((ZERO_REG != 0) && (waddr_i[j*ADDR_WIDTH +: ADDR_WIDTH] == '0))) begin
                mem_d[waddr_i[j*ADDR_WIDTH +: ADDR_WIDTH]] = {wpar[j], wdata_i[j*DATA_WIDTH +: DATA_WIDTH]};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mem_q <= '{default: ZERO_CW};
        end else begin
            mem_q <= mem_d;
        end
    end

    always_comb begin
        rdata_o = '0;
        rerr_o  = '0;
        rd_cw   = '{default: '0};
        for (int unsigned p = 0; p < NUM_READ_PORTS; p++) begin
            rd_cw[p] = mem_q[raddr_i[p*ADDR_WIDTH +: ADDR_WIDTH]];
            rdata_o[p*DATA_WIDTH +: DATA_WIDTH] = rd_cw[p][DATA_WIDTH-1:0];
            rerr_o[p] = gen_par(rd_cw[p][DATA_WIDTH-1:0]) != rd_cw[p][CW_WIDTH-1:DATA_WIDTH];
        end
    end

    always_comb begin
        chk_cw = mem_q[ptr_q];
        wr_hit = 1'b0;
        for (int unsigned j = 0; j < NUM_WRITE_PORTS; j++) begin
            if (we_i[j] && (waddr_i[j*ADDR_WIDTH +: ADDR_WIDTH] == ptr_q)) begin
                wr_hit = 1'b1;
            end
        end
        scrub_fail = (state_q == S_CHECK) && !wr_hit &&
                     (gen_par(chk_cw[DATA_WIDTH-1:0]) != chk_cw[CW_WIDTH-1:DATA_WIDTH]);
    end

    // The CHECK cycle fills the last slot of the interval, so WAIT leaves one count
    // early and the check period stays exactly SCRUB_INTERVAL enabled cycles.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_WAIT;
            cnt_q       <= '0;
            ptr_q       <= PTR_FIRST;
            scrub_err_q <= 1'b0;
            err_addr_q  <= '0;
            sticky_q    <= 1'b0;
        end else begin
            scrub_err_q <= scrub_fail;
            sticky_q    <= (sticky_q & ~err_clr_i) | (|rerr_o) | scrub_fail;
            if (scrub_fail) begin
                err_addr_q <= ptr_q;
            end
            case (state_q)
                S_WAIT: begin
                    if (scrub_en_i) begin
                        if (cnt_q == CNT_WIDTH'(SCRUB_INTERVAL - 2)) begin
                            state_q <= S_CHECK;
                            cnt_q   <= '0;
                        end else begin
                            cnt_q <= cnt_q + CNT_WIDTH'(1);
                        end
                    end
                end
                S_CHECK: begin
                    ptr_q   <= (ptr_q == ADDR_WIDTH'(NUM_WORDS - 1)) ? PTR_FIRST : ptr_q + ADDR_WIDTH'(1);
                    state_q <= S_WAIT;
                end
                default: state_q <= S_WAIT;
            endcase
        end
    end

    assign scrub_ptr_o      = ptr_q;
    assign scrub_err_o      = scrub_err_q;
    assign scrub_err_addr_o = err_addr_q;
    assign err_sticky_o     = sticky_q;

endmodule

// File: tb/tb_cv32e40s_register_file_scrub.sv
// Bench for cv32e40s_register_file_scrub: directed vector table, scrub timing sequences
// and a random phase checked against a word-level reference model.
module tb_cv32e40s_register_file_scrub;

    localparam int NW = 32;
    localparam int DW = 32;
    localparam int AW = 5;
    localparam int NR = 2;
    localparam int NP = 2;
    localparam int IV = 16;

    logic              clk = 1'b0;
    logic              rst;
    logic [NR*AW-1:0]  raddr;
    logic [NR*DW-1:0]  rdata;
    logic [NR-1:0]     rerr;
    logic [NP*AW-1:0]  waddr;
    logic [NP*DW-1:0]  wdata;
    logic [NP-1:0]     we;
    logic [NP-1:0]     winj;
    logic              scrub_en;
    logic [AW-1:0]     sptr;
    logic              serr;
    logic [AW-1:0]     seaddr;
    logic              sticky;
    logic              clr;

    cv32e40s_register_file_scrub #(
        .NUM_WORDS(NW), .DATA_WIDTH(DW), .NUM_READ_PORTS(NR), .NUM_WRITE_PORTS(NP),
        .ZERO_REG(1), .SCRUB_INTERVAL(IV)
    ) dut (
        .clk(clk), .rst(rst), .raddr_i(raddr), .rdata_o(rdata), .rerr_o(rerr),
        .waddr_i(waddr), .wdata_i(wdata), .we_i(we), .winj_i(winj),
        .scrub_en_i(scrub_en), .scrub_ptr_o(sptr), .scrub_err_o(serr),
        .scrub_err_addr_o(seaddr), .err_sticky_o(sticky), .err_clr_i(clr)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // Reference model: word contents plus a "parity corrupted" flag per word.
    logic [DW-1:0] m_data [NW];
    bit            m_bad  [NW];
    int            m_wait_left;
    bit            m_check;
    int            m_ptr;
    bit            m_pulse;
    int            m_eaddr;
    bit            m_sticky;

    typedef struct {
        bit          w0; logic [AW-1:0] a0; logic [DW-1:0] d0; bit i0;
        bit          w1; logic [AW-1:0] a1; logic [DW-1:0] d1; bit i1;
        logic [AW-1:0] ra; logic [DW-1:0] ed; bit ee;
    } vec_t;
    vec_t tbl [7];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NW; i++) begin
            m_data[i] = '0;
            m_bad[i]  = 1'b0;
        end
        m_wait_left = IV - 1;
        m_check     = 1'b0;
        m_ptr       = 1;
        m_pulse     = 1'b0;
        m_eaddr     = 0;
        m_sticky    = 1'b0;
    endtask

    task automatic idle();
        we   = '0;
        winj = '0;
        clr  = 1'b0;
        waddr = '0;
        wdata = '0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        cyc = 0;
    endtask

    // One clock: compare outputs against the model mid-cycle, then advance the model.
    task automatic cycle();
        bit any_rerr;
        bit hit;
        bit fail;
        int a;
        @(negedge clk);
        any_rerr = 1'b0;
        for (int p = 0; p < NR; p++) begin
            a = int'(raddr[p*AW +: AW]);
            chk("rdata", rdata[p*DW +: DW], m_data[a]);
            chk("rerr", rerr[p], m_bad[a]);
            any_rerr |= m_bad[a];
        end
        chk("scrub_ptr", sptr, m_ptr);
        chk("scrub_err", serr, m_pulse);
        chk("scrub_err_addr", seaddr, m_eaddr);
        chk("sticky", sticky, m_sticky);

        hit = 1'b0;
        for (int j = 0; j < NP; j++)
            if (we[j] && int'(waddr[j*AW +: AW]) == m_ptr) hit = 1'b1;
        fail = m_check && m_bad[m_ptr] && !hit;
        m_pulse = fail;
        if (fail) m_eaddr = m_ptr;
        m_sticky = (m_sticky && !clr) || any_rerr || fail;
        for (int j = 0; j < NP; j++) begin
            a = int'(waddr[j*AW +: AW]);
            if (we[j] && a != 0) begin
                m_data[a] = wdata[j*DW +: DW];
                m_bad[a]  = winj[j];
            end
        end
        if (m_check) begin
            m_ptr       = (m_ptr == NW - 1) ? 1 : m_ptr + 1;
            m_check     = 1'b0;
            m_wait_left = IV - 1;
        end else if (scrub_en) begin
            m_wait_left--;
            if (m_wait_left == 0) m_check = 1'b1;
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    initial begin
        int pulses;
        int first_pulse;
        int second_pulse;

        rst = 1'b1; scrub_en = 1'b0; raddr = '0;
        idle();
        do_reset();

        // Reset state across every address on both ports
        chk("reset_ptr", sptr, 1);
        chk("reset_sticky", sticky, 0);
        chk("reset_serr", serr, 0);
        for (int a = 0; a < NW; a++) begin
            raddr = {5'(NW - 1 - a), 5'(a)};
            #1;
            chk("reset_rdata0", rdata[DW-1:0], 0);
            chk("reset_rdata1", rdata[2*DW-1:DW], 0);
            chk("reset_rerr", rerr, 0);
            cycle();
        end

        // Directed write/read vectors
        tbl[0] = '{1, 5,  32'hDEAD_BEEF, 0, 0, 0,  32'h0,         0, 5,  32'hDEAD_BEEF, 0};
        tbl[1] = '{1, 7,  32'h1,         0, 1, 7,  32'h2,         0, 7,  32'h2,         0};
        tbl[2] = '{1, 0,  32'hFFFF_FFFF, 0, 0, 0,  32'h0,         0, 0,  32'h0,         0};
        tbl[3] = '{1, 9,  32'h1234_5678, 1, 0, 0,  32'h0,         0, 9,  32'h1234_5678, 1};
        tbl[4] = '{1, 9,  32'h0,         0, 1, 10, 32'hAAAA_5555, 1, 10, 32'hAAAA_5555, 1};
        tbl[5] = '{1, 12, 32'h0000_FF00, 1, 1, 12, 32'h0000_00FF, 0, 12, 32'h0000_00FF, 0};
        tbl[6] = '{0, 0,  32'h0,         0, 0, 0,  32'h0,         0, 9,  32'h0,         0};
        foreach (tbl[i]) begin
            we    = {tbl[i].w1, tbl[i].w0};
            winj  = {tbl[i].i1, tbl[i].i0};
            waddr = {tbl[i].a1, tbl[i].a0};
            wdata = {tbl[i].d1, tbl[i].d0};
            cycle();
            idle();
            raddr = {tbl[i].ra, tbl[i].ra};
            #1;
            chk("vec_rdata0", rdata[DW-1:0], tbl[i].ed);
            chk("vec_rdata1", rdata[2*DW-1:DW], tbl[i].ed);
            chk("vec_rerr", rerr, {tbl[i].ee, tbl[i].ee});
            cycle();
        end

        // Read error sets sticky; clear only takes effect once x9 is no longer addressed
        do_reset();
        we = 2'b01; waddr = {5'd0, 5'd9}; wdata = {32'h0, 32'h1234_5678}; winj = 2'b01;
        raddr = '0;
        cycle();
        idle();
        raddr = {5'd9, 5'd1};
        #1;
        chk("x9_rerr", rerr, 2'b10);
        chk("x9_sticky_before", sticky, 0);
        cycle();
        chk("x9_sticky_set", sticky, 1);
        clr = 1'b1;
        cycle();
        chk("x9_sticky_set_wins", sticky, 1);
        raddr = {5'd2, 5'd1};
        cycle();
        clr = 1'b0;
        chk("x9_sticky_cleared", sticky, 0);
        cycle();

        // Full sweep with x3 corrupted: one pulse per sweep, pointer wraps 31 -> 1
        do_reset();
        scrub_en = 1'b1; raddr = '0;
        we = 2'b01; waddr = {5'd0, 5'd3}; wdata = {32'h0, 32'hCAFE_0003}; winj = 2'b01;
        cycle();
        idle();
        pulses = 0; first_pulse = -1; second_pulse = -1;
        while (cyc < 560) begin
            cycle();
            if (cyc == 495) chk("ptr_before_wrap", sptr, 31);
            if (cyc == 496) chk("ptr_after_wrap", sptr, 1);
            if (serr) begin
                pulses++;
                if (pulses == 1) first_pulse = cyc;
                if (pulses == 2) second_pulse = cyc;
                chk("sweep_err_addr", seaddr, 3);
            end
        end
        chk("sweep_pulse_count", pulses, 2);
        chk("sweep_first_pulse", first_pulse, 48);
        chk("sweep_second_pulse", second_pulse, 48 + 31 * IV);

        // A write to the address under check suppresses that check
        do_reset();
        scrub_en = 1'b1;
        we = 2'b01; waddr = {5'd0, 5'd3}; wdata = {32'h0, 32'hCAFE_0003}; winj = 2'b01;
        cycle();
        idle();
        while (cyc < 47) cycle();
        we = 2'b10; waddr = {5'd3, 5'd0}; wdata = {32'h0F0F_0F0F, 32'h0};
        cycle();
        idle();
        chk("skip_no_err", serr, 0);
        chk("skip_ptr_adv", sptr, 4);
        chk("skip_sticky", sticky, 0);
        for (int i = 0; i < 4; i++) cycle();

        // Enable held low 10 cycles delays the first check by 10; reset discards a pending check
        do_reset();
        scrub_en = 1'b1;
        we = 2'b11; waddr = {5'd2, 5'd1}; wdata = {32'h0000_0002, 32'h0000_0001}; winj = 2'b11;
        cycle();
        idle();
        pulses = 0; first_pulse = -1;
        while (cyc < 41) begin
            if (cyc == 5) scrub_en = 1'b0;
            if (cyc == 15) scrub_en = 1'b1;
            cycle();
            if (serr) begin
                pulses++;
                if (pulses == 1) first_pulse = cyc;
            end
        end
        chk("gated_pulse_count", pulses, 1);
        chk("gated_first_pulse", first_pulse, 26);
        chk("gated_err_addr", seaddr, 1);
        do_reset();
        chk("midrst_serr", serr, 0);
        chk("midrst_ptr", sptr, 1);
        chk("midrst_sticky", sticky, 0);
        chk("midrst_err_addr", seaddr, 0);
        raddr = {5'd2, 5'd1};
        #1;
        chk("midrst_rdata", rdata, '0);
        cycle();

        // Randomized traffic against the reference model
        do_reset();
        for (int n = 0; n < 1500; n++) begin
            we       = NP'($urandom);
            waddr    = NP*AW'($urandom);
            wdata    = {$urandom, $urandom};
            winj     = {($urandom % 8) == 0, ($urandom % 8) == 0};
            raddr    = NR*AW'($urandom);
            scrub_en = ($urandom % 8) != 0;
            clr      = ($urandom % 16) == 0;
            cycle();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
